// File: rtl/alarm_clock_multi_pkg.sv
// Shared types, limits and BCD helpers for the multi-alarm real-time clock.
package alarm_clock_pkg;

    typedef struct packed {
        logic [4:0] hr;
        logic [5:0] min;
        logic [5:0] sec;
    } clk_time_t;

    typedef enum logic [1:0] {
        RS_IDLE     = 2'd0,
        RS_RINGING  = 2'd1,
        RS_SNOOZING = 2'd2
    } ring_state_t;

    localparam logic [4:0] HR_MAX  = 5'd23;
    localparam logic [5:0] MIN_MAX = 6'd59;
    localparam logic [5:0] SEC_MAX = 6'd59;

    function automatic logic [7:0] bin2bcd(input logic [5:0] v);
        return {4'(v / 6'd10), 4'(v % 6'd10)};
    endfunction

    function automatic logic [6:0] bcd2bin(input logic [7:0] b);
        return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
    endfunction

    // Digit check guards the conversion, which may wrap for non-BCD input.
    function automatic logic bcd_valid(input logic [7:0] b, input logic [6:0] max);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (bcd2bin(b) <= max);
    endfunction

endpackage

// File: rtl/alarm_clock_multi_tick_gen.sv
// Prescaler dividing clk down to a one-second wrap strobe and registered tick pulse.
module tick_gen #(
    parameter int unsigned CLK_HZ = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic wrap,
    output logic tick_1s
);

    localparam int unsigned CW = $clog2(CLK_HZ);

    logic [CW-1:0] cnt;

    // A clear beats a wrap landing on the same edge.
    assign wrap = (cnt == CW'(CLK_HZ - 1)) && !clr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            tick_1s <= 1'b0;
        end else begin
            tick_1s <= wrap;
            if (clr || wrap)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/alarm_clock_multi.sv
// Real-time clock with N programmable alarms, 12/24-h display and validated loads.
// Define ALARM_SNOOZE_EN to build the snooze counter and SNOOZING state.
module alarm_clock_multi
    import alarm_clock_pkg::*;
#(
    parameter  int unsigned CLK_HZ     = 10,
    parameter  int unsigned N_ALARMS   = 4,
    parameter  int unsigned SNOOZE_MIN = 5,
    localparam int unsigned AW         = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          hr_in,
    input  logic [7:0]          min_in,
    input  logic                ld_time,
    input  logic                ld_alarm,
    input  logic [AW-1:0]       alarm_sel,
    input  logic [N_ALARMS-1:0] al_on,
    input  logic                mode_12h,
    input  logic                stop,
    input  logic                snooze,
    output logic [7:0]          hr_out,
    output logic [7:0]          min_out,
    output logic [7:0]          sec_out,
    output logic                pm,
    output logic                tick_1s,
    output logic                alarm,
    output logic [AW-1:0]       alarm_id,
    output logic                ld_err
);

    clk_time_t   cur, nxt;
    ring_state_t state;
    logic [4:0]  slot_hr  [N_ALARMS];
    logic [5:0]  slot_min [N_ALARMS];
    logic [N_ALARMS-1:0] armed;
    logic        ld_ok, time_ld, wrap, hit, match;
    logic [AW-1:0] hit_id;
    logic [4:0]  in_hr, disp_hr;
    logic [5:0]  in_min;

    assign ld_ok   = bcd_valid(hr_in, 7'(HR_MAX)) && bcd_valid(min_in, 7'(MIN_MAX));
    assign in_hr   = 5'(bcd2bin(hr_in));
    assign in_min  = 6'(bcd2bin(min_in));
    assign time_ld = ld_time && ld_ok;

    tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk     (clk),
        .reset   (reset),
        .clr     (time_ld),
        .wrap    (wrap),
        .tick_1s (tick_1s)
    );

    always_comb begin
        nxt = cur;
        if (time_ld) begin
            nxt.hr  = in_hr;
            nxt.min = in_min;
            nxt.sec = '0;
        end else if (wrap) begin
            if (cur.sec == SEC_MAX) begin
                nxt.sec = '0;
                if (cur.min == MIN_MAX) begin
                    nxt.min = '0;
                    nxt.hr  = (cur.hr == HR_MAX) ? '0 : cur.hr + 5'd1;
                end else begin
                    nxt.min = cur.min + 6'd1;
                end
            end else begin
                nxt.sec = cur.sec + 6'd1;
            end
        end
    end

    // Compare against the time about to be shown so alarm rises with it.
    always_comb begin
        hit    = 1'b0;
        hit_id = '0;
        for (int unsigned i = 0; i < N_ALARMS; i++) begin
            if (!hit && armed[i] && al_on[i] && slot_hr[i] == nxt.hr && slot_min[i] == nxt.min) begin
                hit    = 1'b1;
                hit_id = AW'(i);
            end
        end
    end
    assign match = hit && wrap && (nxt.sec == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur    <= '0;
            armed  <= '0;
            ld_err <= 1'b0;
            pm     <= 1'b0;
            for (int unsigned i = 0; i < N_ALARMS; i++) begin
                slot_hr[i]  <= '0;
                slot_min[i] <= '0;
            end
        end else begin
            cur    <= nxt;
            ld_err <= (ld_time || ld_alarm) && !ld_ok;
            pm     <= (nxt.hr >= 5'd12);
            if (ld_alarm && ld_ok && (32'(alarm_sel) < N_ALARMS)) begin
                slot_hr[alarm_sel]  <= in_hr;
                slot_min[alarm_sel] <= in_min;
                armed[alarm_sel]    <= 1'b1;
            end
        end
    end

`ifdef ALARM_SNOOZE_EN
    localparam logic [11:0] SNOOZE_SECS = 12'(SNOOZE_MIN * 60);
    logic [11:0] snz_cnt;
`else
    logic unused_snooze;
    assign unused_snooze = snooze | (SNOOZE_MIN == 0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RS_IDLE;
            alarm    <= 1'b0;
            alarm_id <= '0;
`ifdef ALARM_SNOOZE_EN
            snz_cnt  <= '0;
`endif
        end else begin
            case (state)
                RS_IDLE: if (match) begin
                    state    <= RS_RINGING;
                    alarm    <= 1'b1;
                    alarm_id <= hit_id;
                end
                RS_RINGING: begin
                    if (stop) begin
                        state <= RS_IDLE;
                        alarm <= 1'b0;
                    end
`ifdef ALARM_SNOOZE_EN
                    else if (snooze) begin
                        state   <= RS_SNOOZING;
                        alarm   <= 1'b0;
                        snz_cnt <= SNOOZE_SECS;
                    end
`endif
                end
`ifdef ALARM_SNOOZE_EN
                RS_SNOOZING: begin
                    if (stop) begin
                        state <= RS_IDLE;
                    end else if (match) begin
                        state    <= RS_RINGING;
                        alarm    <= 1'b1;
                        alarm_id <= hit_id;
                    end else if (wrap) begin
                        if (snz_cnt <= 12'd1) begin
                            state <= RS_RINGING;
                            alarm <= 1'b1;
                        end else begin
                            snz_cnt <= snz_cnt - 12'd1;
                        end
                    end
                end
`endif
                default: begin
                    state <= RS_IDLE;
                    alarm <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        disp_hr = cur.hr;
        if (mode_12h) begin
            if (cur.hr == 5'd0)
                disp_hr = 5'd12;
            else if (cur.hr > 5'd12)
                disp_hr = cur.hr - 5'd12;
        end
    end

    assign hr_out  = bin2bcd(6'(disp_hr));
    assign min_out = bin2bcd(cur.min);
    assign sec_out = bin2bcd(cur.sec);

endmodule

// File: tb/tb_alarm_clock_multi.sv
// Self-checking bench for alarm_clock_multi: directed sequences, load table, random run vs. seconds-of-day model.
module tb_alarm_clock_multi;

    localparam int CLK_HZ = 10;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ = 1'b1;
`else
    localparam bit SNZ = 1'b0;
`endif

    logic       clk, reset;
    logic [7:0] hr_in, min_in;
    logic       ld_time, ld_alarm, mode_12h, stop, snooze;
    logic [1:0] alarm_sel;
    logic [3:0] al_on;
    logic [7:0] hr_out, min_out, sec_out;
    logic       pm, tick_1s, alarm, ld_err;
    logic [1:0] alarm_id;

    alarm_clock_multi #(.CLK_HZ(10), .N_ALARMS(4), .SNOOZE_MIN(5)) dut (
        .clk(clk), .reset(reset), .hr_in(hr_in), .min_in(min_in),
        .ld_time(ld_time), .ld_alarm(ld_alarm), .alarm_sel(alarm_sel),
        .al_on(al_on), .mode_12h(mode_12h), .stop(stop), .snooze(snooze),
        .hr_out(hr_out), .min_out(min_out), .sec_out(sec_out), .pm(pm),
        .tick_1s(tick_1s), .alarm(alarm), .alarm_id(alarm_id), .ld_err(ld_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: time as seconds of day, slots as minutes of day.
    int m_t, m_ph, m_left, m_id;
    int m_slot [4];
    bit m_armed [4];
    bit m_tick, m_err, m_ring, m_snz;

    function automatic int bcd2i(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] i2bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_ph = 0; m_left = 0; m_id = 0;
        m_tick = 0; m_err = 0; m_ring = 0; m_snz = 0;
        for (int n = 0; n < 4; n++) begin
            m_slot[n] = 0;
            m_armed[n] = 0;
        end
    endtask

    task automatic model_step();
        int h, mi, hit;
        bit ok;
        h  = bcd2i(hr_in);
        mi = bcd2i(min_in);
        ok = (hr_in[7:4] <= 9) && (hr_in[3:0] <= 9) && (min_in[7:4] <= 9) &&
             (min_in[3:0] <= 9) && (h <= 23) && (mi <= 59);
        m_err  = (ld_time || ld_alarm) && !ok;
        m_tick = 0;
        if (ld_time && ok) begin
            m_t  = h * 3600 + mi * 60;
            m_ph = 0;
        end else if (m_ph == CLK_HZ - 1) begin
            m_ph   = 0;
            m_tick = 1;
            m_t    = (m_t + 1) % 86400;
        end else begin
            m_ph++;
        end
        hit = -1;
        if (m_tick && (m_t % 60 == 0))
            for (int n = 0; n < 4; n++)
                if (hit < 0 && m_armed[n] && al_on[n] && m_slot[n] == m_t / 60)
                    hit = n;
        if (m_ring) begin
            if (stop) m_ring = 0;
            else if (snooze && SNZ) begin
                m_ring = 0; m_snz = 1; m_left = 300;
            end
        end else if (m_snz) begin
            if (stop) m_snz = 0;
            else if (hit >= 0) begin
                m_snz = 0; m_ring = 1; m_id = hit;
            end else if (m_tick) begin
                if (m_left <= 1) begin
                    m_snz = 0; m_ring = 1;
                end else m_left--;
            end
        end else if (hit >= 0) begin
            m_ring = 1; m_id = hit;
        end
        if (ld_alarm && ok) begin
            m_slot[alarm_sel]  = h * 60 + mi;
            m_armed[alarm_sel] = 1;
        end
    endtask

    task automatic step();
        int hh, disp;
        logic [29:0] exp_v, act_v;
        @(posedge clk);
        #1;
        model_step();
        hh   = m_t / 3600;
        disp = mode_12h ? ((hh % 12 == 0) ? 12 : hh % 12) : hh;
        exp_v = {i2bcd(disp), i2bcd((m_t / 60) % 60), i2bcd(m_t % 60),
                 hh >= 12, m_tick, m_ring, 2'(m_id), m_err};
        act_v = {hr_out, min_out, sec_out, pm, tick_1s, alarm, alarm_id, ld_err};
        chk("cycle", {2'b0, act_v}, {2'b0, exp_v});
    endtask

    task automatic load_time(input logic [7:0] h, input logic [7:0] m);
        hr_in = h; min_in = m; ld_time = 1'b1;
        step();
        ld_time = 1'b0;
    endtask

    task automatic load_alarm(input logic [1:0] sel, input logic [7:0] h, input logic [7:0] m);
        hr_in = h; min_in = m; alarm_sel = sel; ld_alarm = 1'b1;
        step();
        ld_alarm = 1'b0;
    endtask

    typedef struct {
        logic [7:0] hr_in, min_in;
        logic       mode;
        logic [7:0] exp_hr, exp_min;
        logic       exp_pm, exp_err;
    } vec_t;
    vec_t tbl [9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        tbl[0] = '{8'h12, 8'h05, 1'b1, 8'h12, 8'h05, 1'b1, 1'b0};
        tbl[1] = '{8'h13, 8'h00, 1'b1, 8'h01, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'h00, 8'h30, 1'b1, 8'h12, 8'h30, 1'b0, 1'b0};
        tbl[3] = '{8'h23, 8'h59, 1'b0, 8'h23, 8'h59, 1'b1, 1'b0};
        tbl[4] = '{8'h11, 8'h11, 1'b1, 8'h11, 8'h11, 1'b0, 1'b0};
        tbl[5] = '{8'h24, 8'h00, 1'b1, 8'h11, 8'h11, 1'b0, 1'b1};
        tbl[6] = '{8'h10, 8'h5A, 1'b1, 8'h11, 8'h11, 1'b0, 1'b1};
        tbl[7] = '{8'h1A, 8'h00, 1'b0, 8'h11, 8'h11, 1'b0, 1'b1};
        tbl[8] = '{8'h09, 8'h59, 1'b0, 8'h09, 8'h59, 1'b0, 1'b0};

        reset = 1'b1; hr_in = '0; min_in = '0; ld_time = 0; ld_alarm = 0;
        alarm_sel = '0; al_on = '0; mode_12h = 0; stop = 0; snooze = 0;
        model_reset();
        #12;
        chk("rst_outs", {hr_out, min_out, sec_out, pm, tick_1s, alarm, alarm_id, ld_err}, 30'd0);
        mode_12h = 1'b1;
        #1;
        chk("rst_hr12", hr_out, 8'h12);
        mode_12h = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;

        // First tick after CLK_HZ cycles, one minute after 600.
        for (int c = 1; c <= 600; c++) begin
            step();
            if (c == 9)  chk("tick_early", tick_1s, 1'b0);
            if (c == 10) chk("tick_first", tick_1s, 1'b1);
        end
        chk("min_600", min_out, 8'h01);
        chk("sec_600", sec_out, 8'h00);

        // Midnight rollover in both display modes.
        load_time(8'h23, 8'h59);
        repeat (600) step();
        chk("midn_time", {hr_out, min_out, sec_out, pm}, {8'h00, 8'h00, 8'h00, 1'b0});
        mode_12h = 1'b1;
        load_time(8'h23, 8'h59);
        repeat (600) step();
        chk("midn_hr12", {hr_out, pm}, {8'h12, 1'b0});
        mode_12h = 1'b0;

        foreach (tbl[i]) begin
            mode_12h = tbl[i].mode;
            load_time(tbl[i].hr_in, tbl[i].min_in);
            chk("tbl_hr",  hr_out,  tbl[i].exp_hr);
            chk("tbl_min", min_out, tbl[i].exp_min);
            chk("tbl_pm",  pm,      tbl[i].exp_pm);
            chk("tbl_err", ld_err,  tbl[i].exp_err);
        end
        mode_12h = 1'b0;

        // Two slots at the same time: lowest index wins.
        load_alarm(2'd2, 8'h07, 8'h00);
        load_alarm(2'd0, 8'h07, 8'h00);
        al_on = 4'b0101;
        load_time(8'h06, 8'h59);
        repeat (599) step();
        chk("ring_before", alarm, 1'b0);
        step();
        chk("ring_at", {hr_out, min_out, sec_out, alarm, alarm_id}, {8'h07, 8'h00, 8'h00, 1'b1, 2'd0});
        repeat (30) step();
        chk("ring_0703", sec_out, 8'h03);
        snooze = 1'b1;
        step();
        snooze = 1'b0;
        chk("snooze_alarm", alarm, SNZ ? 1'b0 : 1'b1);
        found = 0;
        for (int c = 0; c < 3100 && !found; c++) begin
            step();
            if (min_out == 8'h05 && sec_out == 8'h03) found = 1;
        end
        chk("snooze_reach", found, 1'b1);
        chk("snooze_ring", {alarm, alarm_id}, {1'b1, 2'd0});
        stop = 1'b1;
        step();
        chk("stop_alarm", alarm, 1'b0);
        step();
        stop = 1'b0;
        chk("stop_idle", alarm, 1'b0);

        // ld_time on the wrap edge wins over the tick.
        for (int k = 0; k < 10 && m_ph != CLK_HZ - 1; k++) step();
        load_time(8'h10, 8'h00);
        chk("ld_vs_tick", {hr_out, min_out, sec_out, tick_1s}, {8'h10, 8'h00, 8'h00, 1'b0});

        // Asynchronous reset while ringing.
        load_time(8'h06, 8'h59);
        repeat (600) step();
        chk("ring_again", alarm, 1'b1);
        reset = 1'b1;
        #2;
        chk("rst_ring", {hr_out, min_out, sec_out, pm, tick_1s, alarm, alarm_id, ld_err}, 30'd0);
        model_reset();
        reset = 1'b0;

        al_on = 4'b1111;
        for (int i = 0; i < 3000; i++) begin
            int r, h, m;
            r = int'($urandom_range(0, 999));
            ld_time  = (r < 3) || (r == 8);
            ld_alarm = (r >= 3 && r <= 8);
            alarm_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) begin
                hr_in  = 8'($urandom_range(0, 255));
                min_in = 8'($urandom_range(0, 255));
            end else begin
                h = int'($urandom_range(6, 7));
                m = (h == 6) ? int'($urandom_range(57, 59)) : int'($urandom_range(0, 2));
                hr_in  = i2bcd(h);
                min_in = i2bcd(m);
            end
            stop   = ($urandom_range(0, 99) < 2);
            snooze = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 199) == 0) al_on = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0)  mode_12h = ~mode_12h;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
